// File: rtl/baud_gen_frac_pkg.sv
// baud_pkg: shared constants and divisor helpers for the fractional baud generator
package baud_pkg;
  localparam int DIV_MIN = 2;
  function automatic longint unsigned default_div(input longint unsigned clk_freq,
                                                  input longint unsigned baud_rate,
                                                  input longint unsigned oversample,
                                                  input int frac_w);
    return (clk_freq << frac_w) / (baud_rate * oversample);
  endfunction
  function automatic int os_width(input int oversample);
    return $clog2(oversample);
  endfunction
endpackage

// File: rtl/baud_gen_frac_prescaler.sv
// baud_prescaler: fractional-N divider emitting a one-cycle tick per period
module baud_prescaler #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              extra;
  logic [DIV_W:0]    period;
  logic [FRAC_W:0]   sum;
  logic              wrap;
  assign period = {1'b0, div_int} + (DIV_W+1)'(extra);
  assign sum    = {1'b0, acc} + {1'b0, div_frac};
  assign wrap   = {1'b0, cnt} >= period - (DIV_W+1)'(1);
  // Count up to period-1; a carry out of the fraction stretches the next period by one clock
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      extra <= 1'b0;
      tick  <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      acc   <= '0;
      extra <= 1'b0;
      tick  <= 1'b0;
    end else if (!en) begin
      tick  <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      acc   <= sum[FRAC_W-1:0];
      extra <= sum[FRAC_W];
      tick  <= 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      tick  <= 1'b0;
    end
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N UART baud generator with oversample, TX bit and RX mid-bit ticks
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  input  logic              rx_resync,
  output logic              os_tick,
  output logic              tx_tick,
  output logic              rx_mid_tick,
  output logic [DIV_W-1:0]  div_int_cur,
  output logic [FRAC_W-1:0] div_frac_cur
);
  localparam int                OS_W     = os_width(OVERSAMPLE);
  localparam longint unsigned   DEF_DIV  = default_div(longint'(CLK_FREQ), longint'(BAUD_RATE),
                                                       longint'(OVERSAMPLE), FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV);
  localparam logic [DIV_W-1:0]  MIN_DIV  = DIV_W'(DIV_MIN);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  logic [OS_W-1:0] os_cnt, rx_cnt;
  logic            rx_os, rx_clr;
  assign rx_clr      = div_load | rx_resync;
  assign tx_tick     = os_tick & (os_cnt == OS_LAST);
  assign rx_mid_tick = rx_os & (rx_cnt == OS_MID);
  // Active divisor; integer part is clamped so the prescaler period never drops below 2
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_int_cur  <= DEF_INT;
      div_frac_cur <= DEF_FRAC;
    end else if (div_load) begin
      div_int_cur  <= div_int_in < MIN_DIV ? MIN_DIV : div_int_in;
      div_frac_cur <= div_frac_in;
    end
  baud_prescaler #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx (
    .clk(clk), .rst(rst), .en(en), .clr(div_load),
    .div_int(div_int_cur), .div_frac(div_frac_cur), .tick(os_tick)
  );
  baud_prescaler #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx (
    .clk(clk), .rst(rst), .en(en), .clr(rx_clr),
    .div_int(div_int_cur), .div_frac(div_frac_cur), .tick(rx_os)
  );
  // Oversample position within the TX bit
  always_ff @(posedge clk or posedge rst)
    if (rst) os_cnt <= '0;
    else if (div_load) os_cnt <= '0;
    else if (os_tick) os_cnt <= os_cnt == OS_LAST ? '0 : os_cnt + 1'b1;
  // Oversample position within the RX bit, realigned by each start-bit detect
  always_ff @(posedge clk or posedge rst)
    if (rst) rx_cnt <= '0;
    else if (rx_clr) rx_cnt <= '0;
    else if (rx_os) rx_cnt <= rx_cnt == OS_LAST ? '0 : rx_cnt + 1'b1;
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: scoreboard bench checking tick timing of baud_gen_frac
module tb_baud_gen_frac;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, div_load = 1'b0, rx_resync = 1'b0;
  logic [15:0] div_int_in = '0;
  logic [7:0]  div_frac_in = '0;
  logic        os_tick, tx_tick, rx_mid_tick;
  logic [15:0] div_int_cur;
  logic [7:0]  div_frac_cur;
  int          cyc = 0, checks = 0, errors = 0, e;
  bit          mon_on = 1'b0;
  logic [2:0]  seen;
  int          exp_q[3][$];
  string       nm[3] = '{"os_tick", "tx_tick", "rx_mid_tick"};
  int          b, bb, t, ex, acc;

  baud_gen_frac #(.CLK_FREQ(1600), .BAUD_RATE(10), .OVERSAMPLE(16), .DIV_W(16), .FRAC_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .div_load(div_load), .div_int_in(div_int_in),
    .div_frac_in(div_frac_in), .rx_resync(rx_resync), .os_tick(os_tick), .tx_tick(tx_tick),
    .rx_mid_tick(rx_mid_tick), .div_int_cur(div_int_cur), .div_frac_cur(div_frac_cur)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    seen = {rx_mid_tick, tx_tick, os_tick};
    if (mon_on)
      for (int i = 0; i < 3; i++)
        if (seen[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected tick at cycle %0d", nm[i], cyc);
          end else begin
            e = exp_q[i].pop_front();
            if (e != cyc) begin
              errors++;
              $display("FAIL %s: tick at cycle %0d, expected at cycle %0d", nm[i], cyc, e);
            end
          end
        end
  end

  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load(input int di, input int df);
    div_int_in  = 16'(di);
    div_frac_in = 8'(df);
    div_load    = 1'b1;
    @(negedge clk);
    div_load    = 1'b0;
  endtask

  task automatic pulse_resync();
    rx_resync = 1'b1;
    @(negedge clk);
    rx_resync = 1'b0;
  endtask

  task automatic close_window();
    mon_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL %s: %0d expected ticks missing, first due at cycle %0d",
                 nm[i], exp_q[i].size(), exp_q[i][0]);
      end
      exp_q[i].delete();
    end
  endtask

  function automatic void push_every(input int k, input int base, input int step, input int n);
    for (int j = 1; j <= n; j++) exp_q[k].push_back(base + step * j);
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("reset os_tick", int'(os_tick), 0);
    check("reset tx_tick", int'(tx_tick), 0);
    check("reset rx_mid_tick", int'(rx_mid_tick), 0);
    check("reset div_int_cur", int'(div_int_cur), 10);
    check("reset div_frac_cur", int'(div_frac_cur), 0);

    // integer rate straight out of reset
    rst = 1'b0;
    en  = 1'b1;
    b   = cyc;
    push_every(0, b, 10, 32);
    push_every(1, b, 160, 2);
    exp_q[2].push_back(b + 80);
    exp_q[2].push_back(b + 240);
    mon_on = 1'b1;
    wait_cyc(b + 325);
    close_window();

    // fractional rate 10 + 128/256
    load(10, 128);
    b = cyc;
    check("frac load div_int_cur", int'(div_int_cur), 10);
    check("frac load div_frac_cur", int'(div_frac_cur), 128);
    t = b; acc = 0; ex = 0;
    for (int k = 1; k <= 32; k++) begin
      t   = t + 10 + ex;
      acc = acc + 128;
      ex  = acc >> 8;
      acc = acc & 255;
      exp_q[0].push_back(t);
    end
    exp_q[1].push_back(b + 167);
    exp_q[1].push_back(b + 335);
    exp_q[2].push_back(b + 83);
    exp_q[2].push_back(b + 251);
    mon_on = 1'b1;
    wait_cyc(b + 340);
    close_window();

    // RX resync; the third pulse lands exactly when an rx oversample tick is due
    load(10, 0);
    b = cyc;
    push_every(0, b, 10, 50);
    push_every(1, b, 160, 3);
    exp_q[2].push_back(b + 114);
    exp_q[2].push_back(b + 331);
    exp_q[2].push_back(b + 491);
    mon_on = 1'b1;
    wait_cyc(b + 33);
    pulse_resync();
    wait_cyc(b + 200);
    pulse_resync();
    wait_cyc(b + 250);
    pulse_resync();
    wait_cyc(b + 505);
    close_window();

    // clamp to 2, then a mid-count reload suppresses the due tick
    load(0, 0);
    b = cyc;
    check("clamp div_int_cur", int'(div_int_cur), 2);
    check("clamp div_frac_cur", int'(div_frac_cur), 0);
    bb = b + 84;
    push_every(0, b, 2, 41);
    push_every(0, bb, 10, 16);
    exp_q[1].push_back(b + 32);
    exp_q[1].push_back(b + 64);
    exp_q[1].push_back(bb + 160);
    exp_q[2].push_back(b + 16);
    exp_q[2].push_back(b + 48);
    exp_q[2].push_back(b + 80);
    exp_q[2].push_back(bb + 80);
    mon_on = 1'b1;
    wait_cyc(b + 83);
    load(10, 0);
    check("reload div_int_cur", int'(div_int_cur), 10);
    wait_cyc(bb + 165);
    close_window();

    // enable freeze for 37 cycles mid-period
    load(10, 0);
    b = cyc;
    exp_q[0].push_back(b + 10);
    exp_q[0].push_back(b + 20);
    push_every(0, b + 57, 10, 14);
    exp_q[1].push_back(b + 197);
    exp_q[2].push_back(b + 117);
    mon_on = 1'b1;
    wait_cyc(b + 23);
    en = 1'b0;
    wait_cyc(b + 60);
    en = 1'b1;
    wait_cyc(b + 200);
    close_window();

    // asynchronous reset cuts a tick in progress and restores the default divisor
    load(0, 0);
    b = cyc;
    wait_cyc(b + 4);
    check("pre-reset os_tick", int'(os_tick), 1);
    check("pre-reset div_int_cur", int'(div_int_cur), 2);
    rst = 1'b1;
    #1;
    check("async reset os_tick", int'(os_tick), 0);
    check("async reset div_int_cur", int'(div_int_cur), 10);
    check("async reset div_frac_cur", int'(div_frac_cur), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
